bus_responder: RTL and testbench

Memory-mapped byte-wide bus target that answers bus cycles issued by the BIU (biu_top) on the same addr_bus/ale/rd/wr/data lanes. It latches the 20-bit physical address on ALE and decodes it against a base window. On a hit it performs a read or write to an internal byte RAM after a programmable number of wait states and signals completion on ready. It is the memory/peripheral end of the BIU bus and is instantiated beside biu_top in the system top and in BIU benches.

---
 rtl/biu_pkg.sv | 7 +
 rtl/responder_mem.sv | 18 +
 rtl/bus_responder.sv | 110 +++++++++++
 tb/tb_bus_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// biu_pkg: shared BIU bus types and constants
package biu_pkg;
    localparam int PHYS_AW = 20;
    localparam int DATA_W = 8;
    localparam int MAX_WAIT_STATES = 7;
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, ACCESS, HOLD, MISS} resp_state_t;
endpackage

// File: rtl/responder_mem.sv
// responder_mem: single-port byte RAM with registered read port
module responder_mem
    import biu_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/bus_responder.sv
// bus_responder: windowed byte-RAM bus target with programmable wait states
module bus_responder
    import biu_pkg::*;
#(
    parameter logic [PHYS_AW-1:0] BASE_ADDR   = 20'h00000,
    parameter int                 MEM_AW      = 8,
    parameter int                 WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHYS_AW-1:0] addr_bus,
    input  logic               ale,
    input  logic               rd,
    input  logic               wr,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_oe,
    output logic               ready,
    output logic               hit,
    output logic               err
);
    localparam logic [2:0] WS = 3'((WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES);
    resp_state_t state, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [2:0] cnt, cnt_d;
    logic [DATA_W-1:0] dout_d, rdata;
    logic hit_d, rd_dir, rd_dir_d, ready_d, oe_d, err_d, in_win;
    assign in_win = addr_bus[PHYS_AW-1:MEM_AW] == BASE_ADDR[PHYS_AW-1:MEM_AW];
    // addr_q is stable at least one edge before ACCESS, so the registered read is ready in time
    responder_mem #(.AW(MEM_AW)) u_mem (
        .clk  (clk),
        .we   (state == ACCESS && !rd_dir),
        .addr (addr_q),
        .wdata(data_in),
        .rdata(rdata)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            hit      <= 1'b0;
            rd_dir   <= 1'b0;
            cnt      <= '0;
            ready    <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            addr_q   <= addr_d;
            hit      <= hit_d;
            rd_dir   <= rd_dir_d;
            cnt      <= cnt_d;
            ready    <= ready_d;
            data_oe  <= oe_d;
            data_out <= dout_d;
            err      <= err_d;
        end
    end
    always_comb begin
        state_d  = state;
        addr_d   = addr_q;
        hit_d    = hit;
        rd_dir_d = rd_dir;
        cnt_d    = cnt;
        ready_d  = ready;
        oe_d     = data_oe;
        dout_d   = data_out;
        err_d    = 1'b0;
        case (state)
            IDLE, ADDR: begin
                if (ale) begin
                    addr_d  = addr_bus[MEM_AW-1:0];
                    hit_d   = in_win;
                    state_d = ADDR;
                end else if (state == ADDR && rd && wr) begin
                    err_d   = 1'b1;
                    hit_d   = 1'b0;
                    state_d = MISS;
                end else if (state == ADDR && (rd || wr)) begin
                    rd_dir_d = rd;
                    cnt_d    = WS;
                    state_d  = !hit ? MISS : (WS == 3'd0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_d   = cnt - 3'd1;
                state_d = !(rd_dir ? rd : wr) ? IDLE : (cnt == 3'd1) ? ACCESS : WAIT;
            end
            ACCESS: begin
                ready_d = 1'b1;
                oe_d    = rd_dir;
                dout_d  = rd_dir ? rdata : '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (!rd && !wr) begin
                    ready_d = 1'b0;
                    oe_d    = 1'b0;
                    dout_d  = '0;
                    hit_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            MISS: state_d = (!rd && !wr) ? IDLE : MISS;
            default: state_d = IDLE;
        endcase
        if (ale && (state == WAIT || state == ACCESS || state == HOLD || state == MISS)) err_d = 1'b1;
    end
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: scoreboard bench for a WAIT_STATES=2 and a WAIT_STATES=0 responder
module tb_bus_responder;
    typedef struct {
        int         u;
        bit         rd;
        bit         chk;
        logic [7:0] data;
        int         samp;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] addr [2];
    logic        ale [2], rd [2], wr [2];
    logic [7:0]  din [2];
    logic [7:0]  dout [2];
    logic        oe [2], rdy [2], hit_o [2], err_o [2];
    logic        rdy_prev [2] = '{1'b0, 1'b0};
    int          err_cnt [2] = '{0, 0};
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        exp_q [$];
    logic [7:0]  model [2][256];
    bit          vld [2][256];
    logic [7:0]  offs [8] = '{8'h00, 8'h01, 8'h10, 8'h45, 8'h7F, 8'h80, 8'hFE, 8'hFF};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_responder #(.BASE_ADDR(20'h12300), .MEM_AW(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst_n), .addr_bus(addr[0]), .ale(ale[0]), .rd(rd[0]), .wr(wr[0]),
        .data_in(din[0]), .data_out(dout[0]), .data_oe(oe[0]), .ready(rdy[0]), .hit(hit_o[0]), .err(err_o[0]));
    bus_responder #(.BASE_ADDR(20'h12300), .MEM_AW(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst_n), .addr_bus(addr[1]), .ale(ale[1]), .rd(rd[1]), .wr(wr[1]),
        .data_in(din[1]), .data_out(dout[1]), .data_oe(oe[1]), .ready(rdy[1]), .hit(hit_o[1]), .err(err_o[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising ready consumes one scoreboard entry
    for (genvar g = 0; g < 2; g++) begin : mon
        always @(negedge clk) begin
            exp_t e;
            if (err_o[g]) err_cnt[g]++;
            if (rdy[g] && !rdy_prev[g]) begin
                if (exp_q.size() == 0) check("unexpected_ready", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("unit", g, e.u);
                    check("latency", cyc - e.samp, (g == 0) ? 3 : 1);
                    check("data_oe", oe[g], e.rd);
                    if (e.chk) check("data_out", dout[g], e.data);
                end
            end
            rdy_prev[g] = rdy[g];
        end
    end

    task automatic issue(input int u, input logic [19:0] a, input bit r, input bit w,
                         input logic [7:0] d, input bit track);
        exp_t e;
        bit in_win;
        in_win = (a[19:8] == 12'h123);
        @(posedge clk); #1;
        ale[u] = 1'b1; addr[u] = a;
        @(posedge clk); #1;
        check("hit", hit_o[u], in_win);
        ale[u] = 1'b0; rd[u] = r; wr[u] = w; din[u] = d;
        if (track && in_win && (r ^ w)) begin
            e.u = u; e.rd = r; e.chk = r && vld[u][a[7:0]]; e.data = model[u][a[7:0]]; e.samp = cyc + 1;
            exp_q.push_back(e);
            if (w) begin
                model[u][a[7:0]] = d;
                vld[u][a[7:0]] = 1'b1;
            end
        end
    endtask

    task automatic wait_ready(input int u);
        int k;
        k = 0;
        while (!rdy[u] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_timeout", rdy[u], 1);
    endtask

    task automatic finish_cycle(input int u, input bit resp, input int hold);
        if (resp) begin
            wait_ready(u);
            repeat (hold) begin
                @(posedge clk); #1;
                check("ready_held", rdy[u], 1);
            end
        end else begin
            repeat (hold + 1) begin
                @(posedge clk); #1;
                check("miss_quiet", {rdy[u], oe[u], dout[u]}, 0);
            end
        end
        rd[u] = 1'b0; wr[u] = 1'b0;
        @(posedge clk); #1;
        check("ready_fall", {rdy[u], oe[u], hit_o[u]}, 0);
    endtask

    task automatic access(input int u, input logic [19:0] a, input bit r, input bit w,
                          input logic [7:0] d, input int hold);
        int e0;
        bit resp;
        resp = (a[19:8] == 12'h123) && (r ^ w);
        e0 = err_cnt[u];
        issue(u, a, r, w, d, 1'b1);
        finish_cycle(u, resp, hold);
        check("err_count", err_cnt[u] - e0, (r && w) ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int u, kind, e0;
        logic [7:0] off, d;
        logic [19:0] a;
        bit r, w;
        for (int i = 0; i < 2; i++) begin
            ale[i] = 0; rd[i] = 0; wr[i] = 0; din[i] = 0; addr[i] = 0;
        end
        #1;
        for (int i = 0; i < 2; i++) check("reset_state", {dout[i], oe[i], rdy[i], hit_o[i], err_o[i]}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // write then read
        access(0, 20'h12345, 0, 1, 8'hA5, 0);
        access(0, 20'h12345, 1, 0, 8'h00, 1);
        // miss
        access(0, 20'h45600, 1, 0, 8'h00, 5);
        // strobe violation
        access(0, 20'h12310, 0, 1, 8'h11, 0);
        access(0, 20'h12310, 1, 1, 8'h3C, 1);
        access(0, 20'h12310, 1, 0, 8'h00, 0);
        // abort during first wait cycle
        access(0, 20'h12320, 0, 1, 8'h55, 0);
        issue(0, 20'h12320, 0, 1, 8'h77, 1'b0);
        @(posedge clk); #1;
        wr[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_quiet", rdy[0], 0);
        end
        access(0, 20'h12320, 1, 0, 8'h00, 0);
        // asynchronous reset in the middle of a read
        issue(0, 20'h12345, 1, 0, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("hit_pre_reset", hit_o[0], 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {dout[0], oe[0], rdy[0], hit_o[0]}, 0);
        rd[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        access(0, 20'h12345, 1, 0, 8'h00, 0);
        // zero-wait instance with a stray ale in HOLD
        access(1, 20'h12345, 0, 1, 8'h5A, 0);
        access(1, 20'h12345, 1, 0, 8'h00, 1);
        issue(1, 20'h12345, 1, 0, 8'h00, 1'b1);
        wait_ready(1);
        e0 = err_cnt[1];
        ale[1] = 1'b1;
        @(posedge clk); #1;
        ale[1] = 1'b0;
        check("stray_err", err_o[1], 1);
        check("ready_kept", rdy[1], 1);
        @(posedge clk); #1;
        check("err_width", err_o[1], 0);
        check("stray_err_count", err_cnt[1] - e0, 1);
        rd[1] = 1'b0;
        @(posedge clk); #1;
        check("ready_fall", {rdy[1], oe[1], hit_o[1]}, 0);
        // randomized traffic on both instances
        for (int i = 0; i < 60; i++) begin
            u = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            off = offs[$urandom_range(0, 7)];
            d = 8'($urandom);
            a = {12'h123, off};
            if (kind == 0) begin
                r = 1; w = 1;
            end else if (kind == 1) begin
                a = {($urandom_range(0, 1) == 1) ? 12'h122 : 12'h456, off};
                r = 1; w = 0;
            end else begin
                w = !vld[u][off] || ($urandom_range(0, 1) == 1);
                r = !w;
            end
            access(u, a, r, w, d, $urandom_range(0, 2));
        end
        repeat (3) @(posedge clk);
        #1 check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
